// File: rtl/smem_pkg.sv
// Shared definitions for the backward-extension memory request path:
// default sizes, request tag layout and issue FSM encoding.
package smem_pkg;

   localparam int DEF_DEPTH   = 16;
   localparam int DEF_MAX_OUT = 32;
   localparam int DEF_ADDR_W  = 42;
   localparam int DEF_RN_W    = 9;

   // Tag layout, LSB first: merged, sel, read_num.
   localparam int TAG_MERGED_BIT = 0;
   localparam int TAG_SEL_BIT    = 1;
   localparam int TAG_RN_LSB     = 2;

   localparam logic SEL_K = 1'b0;
   localparam logic SEL_L = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE_K = 2'd1,
      ST_ISSUE_L = 2'd2
   } issue_st_e;

   function automatic int tag_w(input int rn_w);
      return rn_w + TAG_RN_LSB;
   endfunction

endpackage

// File: rtl/bwt_req_fifo.sv
// Request FIFO: registered count, full/empty flags.
// Pushes while full are ignored; the owner flags the overflow.
module bwt_req_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [W-1:0]               wdata_i,
   input  logic                       pop_i,
   output logic [W-1:0]               rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointer and count next-state.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (do_push & ~do_pop) cnt_d = cnt_q + 1'b1;
      if (do_pop & ~do_push) cnt_d = cnt_q - 1'b1;
   end

   // Storage array; contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/bwt_req_issue.sv
// Serialises k/l occurrence-line pairs into single memory reads,
// merging same-line pairs, under an outstanding-read credit limit.
module bwt_req_issue
   import smem_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int MAX_OUT = DEF_MAX_OUT,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int RN_W    = DEF_RN_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [ADDR_W-1:0]     req_addr_k,
   input  logic [ADDR_W-1:0]     req_addr_l,
   input  logic [RN_W-1:0]       req_read_num,
   output logic                  stall,
   output logic                  mem_req_valid,
   output logic [ADDR_W-1:0]     mem_req_addr,
   output logic [RN_W+1:0]       mem_req_tag,
   input  logic                  mem_req_ready,
   input  logic                  mem_rsp_valid,
   output logic                  err_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int W  = 2 * ADDR_W + RN_W;
   localparam int CW = $clog2(MAX_OUT + 1);

   issue_st_e         state_q, state_d;
   logic [ADDR_W-1:0] k_q, l_q;
   logic [RN_W-1:0]   rn_q;
   logic [CW-1:0]     out_q, out_d;
   logic              err_q;

   logic              f_pop, f_full, f_empty;
   logic [W-1:0]      f_rdata;
   logic [PW:0]       f_cnt;
   logic              merged, hs;

   bwt_req_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk     (clk),
      .rst_ni  (rst),
      .push_i  (req_valid),
      .wdata_i ({req_addr_k, req_addr_l, req_read_num}),
      .pop_i   (f_pop),
      .rdata_o (f_rdata),
      .full_o  (f_full),
      .empty_o (f_empty),
      .count_o (f_cnt)
   );

   assign merged       = (k_q == l_q);
   assign hs           = mem_req_valid & mem_req_ready;
   assign stall        = (f_cnt >= (PW+1)'(DEPTH - 2));
   assign err_overflow = err_q;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next state and FIFO pop; a pop always refills the hold register.
   always_comb begin
      state_d = state_q;
      f_pop   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!f_empty) begin
               f_pop   = 1'b1;
               state_d = ST_ISSUE_K;
            end
         end
         ST_ISSUE_K: begin
            if (hs) begin
               if (!merged)       state_d = ST_ISSUE_L;
               else if (!f_empty) f_pop   = 1'b1;
               else               state_d = ST_IDLE;
            end
         end
         ST_ISSUE_L: begin
            if (hs) begin
               if (!f_empty) begin
                  f_pop   = 1'b1;
                  state_d = ST_ISSUE_K;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request outputs from state and hold register.
   always_comb begin
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      mem_req_tag   = '0;
      unique case (state_q)
         ST_ISSUE_K: begin
            mem_req_valid = (out_q < CW'(MAX_OUT));
            mem_req_addr  = k_q;
            mem_req_tag   = {rn_q, SEL_K, merged};
         end
         ST_ISSUE_L: begin
            mem_req_valid = (out_q < CW'(MAX_OUT));
            mem_req_addr  = l_q;
            mem_req_tag   = {rn_q, SEL_L, 1'b0};
         end
         default: ;
      endcase
   end

   // Hold register loaded on every pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q  <= '0;
         l_q  <= '0;
         rn_q <= '0;
      end else if (f_pop) begin
         {k_q, l_q, rn_q} <= f_rdata;
      end
   end

   // Outstanding credits; a stray response at zero is absorbed.
   always_comb begin
      out_d = out_q;
      if (hs && !mem_rsp_valid)
         out_d = out_q + 1'b1;
      else if (!hs && mem_rsp_valid && out_q != '0)
         out_d = out_q - 1'b1;
   end

   // Credit counter and sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q <= '0;
         err_q <= 1'b0;
      end else begin
         out_q <= out_d;
         if (req_valid && f_full) err_q <= 1'b1;
      end
   end

endmodule
